// File: rtl/unidade_hilo_pkg.sv
// Shared constants for the execute unit:
// ALU op codes, HI/LO op codes and HI/LO FSM states.
package unidade_hilo_pkg;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLT,
    ALU_SLL,
    ALU_SRL
  } alu_op_t;

  typedef enum logic [1:0] {
    OP_MULT = 2'b00,
    OP_DIV  = 2'b01,
    OP_MTHI = 2'b10,
    OP_MTLO = 2'b11
  } hilo_op_t;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    FIM
  } estado_t;

endpackage

// File: rtl/unidade_hilo_passo_divisao.sv
// One restoring-divide step: shifted partial
// remainder vs divisor -> new remainder, quotient bit.
module passo_divisao #(
  parameter int LARGURA = 32
) (
  input  logic [LARGURA:0]   parcial,
  input  logic [LARGURA-1:0] divisor,
  output logic [LARGURA-1:0] resto,
  output logic               bit_q
);

  logic [LARGURA-1:0] dif;

  // Result always fits in LARGURA bits when it is kept
  assign dif   = parcial[LARGURA-1:0] - divisor;
  assign bit_q = parcial >= {1'b0, divisor};
  assign resto = bit_q ? dif : parcial[LARGURA-1:0];

endmodule

// File: rtl/unidade_hilo.sv
// HI/LO unit: iterative unsigned multiply/divide
// plus MTHI/MTLO moves.
module unidade_hilo
  import unidade_hilo_pkg::*;
#(
  parameter int LARGURA = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [LARGURA-1:0] RS,
  input  logic [LARGURA-1:0] RT,
  output logic               busy,
  output logic               done,
  output logic [LARGURA-1:0] saidaHI,
  output logic [LARGURA-1:0] saidaLO
);

  localparam int CW = $clog2(LARGURA + 1);
  localparam logic [CW-1:0] ULTIMO = CW'(LARGURA - 1);

  estado_t              estado;
  logic [CW-1:0]        cnt;
  logic [2*LARGURA-1:0] mcand;
  logic [2*LARGURA-1:0] acc;
  logic [2*LARGURA-1:0] soma;
  logic [LARGURA-1:0]   mplier;
  logic [LARGURA-1:0]   quoc;
  logic [LARGURA-1:0]   resto;
  logic [LARGURA-1:0]   divisor;
  logic [LARGURA-1:0]   novo_resto;
  logic                 bit_q;

  assign soma = acc + (mplier[0] ? mcand : '0);

  passo_divisao #(.LARGURA(LARGURA)) u_passo (
    .parcial ({resto, quoc[LARGURA-1]}),
    .divisor (divisor),
    .resto   (novo_resto),
    .bit_q   (bit_q)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado  <= IDLE;
      cnt     <= '0;
      mcand   <= '0;
      acc     <= '0;
      mplier  <= '0;
      quoc    <= '0;
      resto   <= '0;
      divisor <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      saidaHI <= '0;
      saidaLO <= '0;
    end else begin
      unique case (estado)
        IDLE: begin
          if (start) begin
            cnt <= '0;
            unique case (hilo_op_t'(op))
              OP_MULT: begin
                mcand  <= {{LARGURA{1'b0}}, RS};
                mplier <= RT;
                acc    <= '0;
                estado <= MUL;
                busy   <= 1'b1;
              end
              OP_DIV: begin
                // Divide by zero finishes at once
                if (RT == '0) begin
                  saidaHI <= RS;
                  saidaLO <= '1;
                  estado  <= FIM;
                  done    <= 1'b1;
                end else begin
                  quoc    <= RS;
                  resto   <= '0;
                  divisor <= RT;
                  estado  <= DIV;
                  busy    <= 1'b1;
                end
              end
              OP_MTHI: begin
                saidaHI <= RS;
                estado  <= FIM;
                done    <= 1'b1;
              end
              OP_MTLO: begin
                saidaLO <= RS;
                estado  <= FIM;
                done    <= 1'b1;
              end
            endcase
          end
        end
        MUL: begin
          acc    <= soma;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == ULTIMO) begin
            {saidaHI, saidaLO} <= soma;
            estado <= FIM;
            busy   <= 1'b0;
            done   <= 1'b1;
          end
        end
        DIV: begin
          quoc  <= {quoc[LARGURA-2:0], bit_q};
          resto <= novo_resto;
          cnt   <= cnt + CW'(1);
          if (cnt == ULTIMO) begin
            saidaLO <= {quoc[LARGURA-2:0], bit_q};
            saidaHI <= novo_resto;
            estado  <= FIM;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        FIM: begin
          estado <= IDLE;
          done   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unidade_hilo.sv
// Directed bench for unidade_hilo: vector table
// plus ignored-start and mid-operation reset sequences.
module tb_unidade_hilo;
  import unidade_hilo_pkg::*;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] RS = '0;
  logic [W-1:0] RT = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] saidaHI;
  logic [W-1:0] saidaLO;

  int n_chk = 0;
  int n_fail = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] rs;
    logic [W-1:0] rt;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           lat;
    int           nbusy;
  } vec_t;

  vec_t tab[12];

  unidade_hilo #(.LARGURA(W)) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .RS      (RS),
    .RT      (RT),
    .busy    (busy),
    .done    (done),
    .saidaHI (saidaHI),
    .saidaLO (saidaLO)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nome,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h",
               nome, act, exp);
    end
  endtask

  // Drive a request at a negedge, then count negedges
  // until done is seen; inputs are scrambled after
  // acceptance to prove the operands were latched.
  task automatic run_op(input logic [1:0] o,
                        input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        output int lat,
                        output int nb,
                        output bit hold_ok);
    @(negedge clock);
    start = 1'b1; op = o; RS = a; RT = b;
    lat = -1; nb = 0; hold_ok = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clock);
      start = 1'b0; RS = ~a; RT = b ^ 32'h5A5A_0001;
      if (done) begin
        lat = k;
        break;
      end
      if (busy) nb++;
      if (saidaHI !== m_hi || saidaLO !== m_lo)
        hold_ok = 1'b0;
    end
  endtask

  initial begin
    int lat;
    int nb;
    bit hold_ok;
    int ndone;
    int nbusy;

    tab[0]  = '{OP_MULT, 32'd7, 32'd6, 32'd0, 32'd42, 33, 32};
    tab[1]  = '{OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF,
                32'hFFFFFFFE, 32'h00000001, 33, 32};
    tab[2]  = '{OP_DIV, 32'd100, 32'd7, 32'd2, 32'd14, 33, 32};
    tab[3]  = '{OP_DIV, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1, 0};
    tab[4]  = '{OP_MTHI, 32'hA5A5A5A5, 32'd9,
                32'hA5A5A5A5, 32'hFFFFFFFF, 1, 0};
    tab[5]  = '{OP_MTLO, 32'd3, 32'd9, 32'hA5A5A5A5, 32'd3, 1, 0};
    tab[6]  = '{OP_MULT, 32'h10000, 32'h10000, 32'd1, 32'd0, 33, 32};
    tab[7]  = '{OP_DIV, 32'hFFFFFFFF, 32'd1,
                32'd0, 32'hFFFFFFFF, 33, 32};
    tab[8]  = '{OP_DIV, 32'd7, 32'd100, 32'd7, 32'd0, 33, 32};
    tab[9]  = '{OP_DIV, 32'hFFFFFFFF, 32'h10,
                32'hF, 32'h0FFFFFFF, 33, 32};
    tab[10] = '{OP_MULT, 32'h80000000, 32'd2, 32'd1, 32'd0, 33, 32};
    tab[11] = '{OP_MULT, 32'd12345, 32'd0, 32'd0, 32'd0, 33, 32};

    repeat (3) @(negedge clock);
    chk("reset_hi", saidaHI, 0);
    chk("reset_lo", saidaLO, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    reset = 1'b1;

    foreach (tab[i]) begin
      run_op(tab[i].op, tab[i].rs, tab[i].rt, lat, nb, hold_ok);
      chk($sformatf("v%0d_latency", i), lat, tab[i].lat);
      chk($sformatf("v%0d_busy_cycles", i), nb, tab[i].nbusy);
      chk($sformatf("v%0d_hilo_hold", i), hold_ok, 1);
      chk($sformatf("v%0d_hi", i), saidaHI, tab[i].hi);
      chk($sformatf("v%0d_lo", i), saidaLO, tab[i].lo);
      m_hi = tab[i].hi;
      m_lo = tab[i].lo;
      @(negedge clock);
      chk($sformatf("v%0d_done_pulse", i), done, 0);
    end

    // start pulses during MULT must be ignored
    @(negedge clock);
    start = 1'b1; op = OP_MULT; RS = 32'd7; RT = 32'd6;
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clock);
      start = (k == 5) || (k == 12) || (k == 32);
      op = (k == 5) ? OP_DIV : OP_MTHI;
      RS = 32'd9; RT = 32'd0;
      if (done) begin
        lat = k;
        break;
      end
    end
    start = 1'b0;
    chk("ign_latency", lat, 33);
    chk("ign_hi", saidaHI, 0);
    chk("ign_lo", saidaLO, 42);
    ndone = 0;
    nbusy = 0;
    repeat (5) begin
      @(negedge clock);
      if (done) ndone++;
      if (busy) nbusy++;
    end
    chk("ign_no_queued_done", ndone, 0);
    chk("ign_no_queued_busy", nbusy, 0);
    chk("ign_hold_lo", saidaLO, 42);

    // reset ten cycles into a DIV
    @(negedge clock);
    start = 1'b1; op = OP_DIV; RS = 32'd100; RT = 32'd7;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    chk("rst_was_busy", busy, 1);
    #2 reset = 1'b0;
    #1;
    chk("rst_hi", saidaHI, 0);
    chk("rst_lo", saidaLO, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clock);
    reset = 1'b1;
    m_hi = '0;
    m_lo = '0;
    ndone = 0;
    nbusy = 0;
    repeat (40) begin
      @(negedge clock);
      if (done) ndone++;
      if (busy) nbusy++;
    end
    chk("rst_no_done", ndone, 0);
    chk("rst_no_busy", nbusy, 0);
    chk("rst_lo_kept", saidaLO, 0);

    run_op(OP_MULT, 32'd2, 32'd3, lat, nb, hold_ok);
    chk("post_rst_latency", lat, 33);
    chk("post_rst_hold", hold_ok, 1);
    chk("post_rst_hi", saidaHI, 0);
    chk("post_rst_lo", saidaLO, 6);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
